// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the hazard unit
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_hilo_rd;
    logic        id_md_start;
    logic        id_md_div;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_busy;
    logic        md_done;
    logic [1:0]  md_state;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_hilo_rd, id_md_start, id_md_div,
               ex_mem_read, ex_rt, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
               md_state, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_hilo_rd, id_md_start, id_md_div,
               ex_mem_read, ex_rt, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
               md_state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / HI-LO hazard stall, branch flush and multiply-divide occupancy FSM
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input logic                    Clk,
    input logic                    Rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_md_busy;
    logic        r_md_done;
    logic [15:0] r_stall_cycles;

    logic w_load_use;
    logic w_md_hazard;
    logic w_stall;
    logic w_accept;

    assign w_load_use  = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                         ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    assign w_md_hazard = (r_state != IDLE) && (bus.id_hilo_rd || bus.id_md_start);
    assign w_stall     = (w_load_use || w_md_hazard) && !bus.branch_taken;
    assign w_accept    = (r_state == IDLE) && bus.id_md_start && !w_stall && !bus.branch_taken;

    assign bus.pc_write     = !w_stall;
    assign bus.ifid_write   = !w_stall;
    assign bus.ifid_flush   = bus.branch_taken;
    assign bus.idex_bubble  = w_stall || bus.branch_taken;
    assign bus.md_busy      = r_md_busy;
    assign bus.md_done      = r_md_done;
    assign bus.md_state     = r_state;
    assign bus.stall_cycles = r_stall_cycles;

    // Once accepted, an op runs to completion regardless of branches or later stalls
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state        <= IDLE;
            r_cnt          <= 6'd0;
            r_md_busy      <= 1'b0;
            r_md_done      <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (w_stall && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state   <= BUSY;
                    r_cnt     <= bus.id_md_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
                    r_md_busy <= 1'b1;
                end
                BUSY: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state   <= DONE;
                        r_md_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= 6'd0;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
            endcase
        end
    end
endmodule
